keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Drives the 4x4 keypad matrix: rotates an active-low strobe across the four columns, samples the four active-low row lines through a two-flop synchronizer, and latches the first pressed key. On a press it presents a one-hot row/column code on `keypad_val`, holds `button_on` high while the key stays down, and pulses `en_ks` once. It sits between the keypad pins and `debounce`, producing that block's `keypad_val`, `button_on` and `en_ks` inputs.

## Interface
- `SCAN_DIV`, 4800: column dwell time in `clk` cycles, and the release-qualification count. Must be ≥ 3.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rows`  in  4  keypad row lines. Active-low. Asynchronous to `clk`. Externally pulled up.
- `cols`  out  4  keypad column strobes. Active-low. At most one bit is low at any time.
- `keypad_val`  out  8  key code `{row_onehot[3:0], col_onehot[3:0]}`, active-high.
- `button_on`  out  1  high while the latched key is considered pressed.
- `en_ks`  out  1  single-cycle pulse when a new key is latched.

## Operation
- Synchronizer: `rows_s = ~rows` through 2 flops. All decisions use `rows_s`.
- States (enum in package): `SCAN`, `HELD`.
- Column index `col_idx` is 2 bits. `cols = ~(4'b0001 << col_idx)`.
- Dwell counter `cnt` is `$clog2(SCAN_DIV)` bits and is shared by both states.
- SCAN:
  - `cnt` increments each cycle.
  - At `cnt == SCAN_DIV-1`, sample `rows_s`.
  - If no row is set: `cnt` goes to 0 and `col_idx` increments, wrapping 3 to 0.
  - If any row is set: latch `row_onehot` as the lowest-index set bit and `col_onehot` from `col_idx`. Load `keypad_val`, set `button_on = 1`, pulse `en_ks`. Go to HELD with `cnt = 0`. `col_idx` is frozen, so `cols` keeps strobing the latched column.
- HELD:
  - Watch only the latched row bit of `rows_s`.
  - If the bit is low, `cnt` increments. If the bit is high, `cnt` goes to 0.
  - At `cnt == SCAN_DIV-1` with the bit low: clear `button_on`, go to SCAN with `cnt = 0` and `col_idx + 1`.
  - Other keys pressed while in HELD are ignored (single-key lockout), including additional rows in the same column.
- `keypad_val` holds its last code after release and changes only on the next latch.
- Reset, from any state and at any cycle including mid-HELD:
  - state = SCAN, `col_idx` = 0, `cols` = 4'b1110, `cnt` = 0
  - `keypad_val` = 8'h00, `button_on` = 0, `en_ks` = 0
  - synchronizer flops = 0 (no key)

## Timing
- All outputs are registered.
- `cols` changes on the edge after the dwell-end sample.
- `keypad_val`, `button_on` and `en_ks` update on the same edge, the one that closes the sampling cycle. `en_ks` is high for exactly 1 cycle.
- Press-to-`en_ks` latency:
  - Minimum: 2 cycles of synchronizer delay plus the remainder of the current dwell.
  - Maximum: 4·`SCAN_DIV` + 2 cycles.
- Release-to-`button_on`-fall: 2 + `SCAN_DIV` cycles, measured from the last row bounce.
- The rows have `SCAN_DIV`-2 cycles to settle after a column change before the sample. Hence `SCAN_DIV` ≥ 3.
- Simultaneous release bounce and `cnt` terminal count: the bounce wins. `cnt` goes to 0 and the block stays in HELD.

## Structure
- Package `keypad_pkg`:
  - `scan_state_t` enum (`SCAN`, `HELD`)
  - `KEY_NONE` = 8'h00
  - `COLS_IDLE` = 4'b1111
- Sub-module `sync2`: a 4-bit two-flop synchronizer with synchronous reset to 0, instantiated on `~rows`.
- Otherwise a single FSM plus counter in `keypad_scanner`.

## Test plan
All scenarios use `SCAN_DIV` = 4.
- Reset: assert `reset` 2 cycles → `cols` = 4'b1110, `keypad_val` = 0, `button_on` = 0, `en_ks` = 0. Then `cols` rotates 1110, 1101, 1011, 0111, 1110, with 4 cycles per step.
- Press: model drives `rows[2]` low whenever `cols[1]` is low → `keypad_val` = 8'b0100_0010, `en_ks` high exactly 1 cycle, `button_on` = 1, `cols` frozen at 4'b1101.
- Lockout: with the key held, also drive `rows[0]` low under column 3 → no `en_ks`, `keypad_val` unchanged.
- Release bounce: release `rows[2]`, re-press after 2 cycles, release again → `button_on` falls exactly `SCAN_DIV` + 2 cycles after the final release. Scan resumes at `cols` = 4'b1011.
- Multi-row: `rows[1]` and `rows[3]` both low under column 0 → `keypad_val` = 8'b0010_0001.
- Reset mid-HELD: assert `reset` while `button_on` = 1 → all outputs return to reset values on the next edge. The next `en_ks` requires a fresh scan.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic {
    SCAN,
    HELD
  } scan_state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [3:0] COLS_IDLE = 4'b1111;

  // Isolates the lowest set bit so multi-row presses resolve to one row.
  function automatic logic [3:0] lowest_set(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    return COLS_IDLE ^ (4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event bundle passed from the scanner to the debounce block.
interface keypad_scanner_if;

  logic [7:0] keypad_val;
  logic       button_on;
  logic       en_ks;

  modport master (output keypad_val, button_on, en_ks);
  modport slave  (input  keypad_val, button_on, en_ks);

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing keypad scanner: latches the first pressed key, holds it
// until the row has been quiet for a full dwell, then resumes scanning.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       rows,
  output logic [3:0]       cols,
  keypad_scanner_if.master kp
);

  localparam int              CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);

  scan_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    col_idx, col_idx_n;
  logic [3:0]    cols_n;
  logic [7:0]    key_q, key_n;
  logic          btn_q, btn_n;
  logic          en_q, en_n;
  logic [3:0]    rows_s;
  logic          held_bit;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (~rows),
    .q     (rows_s)
  );

  assign held_bit      = |(rows_s & key_q[7:4]);
  assign kp.keypad_val = key_q;
  assign kp.button_on  = btn_q;
  assign kp.en_ks      = en_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      cnt     <= '0;
      col_idx <= 2'd0;
      cols    <= col_strobe(2'd0);
      key_q   <= KEY_NONE;
      btn_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      col_idx <= col_idx_n;
      cols    <= cols_n;
      key_q   <= key_n;
      btn_q   <= btn_n;
      en_q    <= en_n;
    end
  end

  // In HELD a row bounce clears the counter before the terminal count can release.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    col_idx_n = col_idx;
    key_n     = key_q;
    btn_n     = btn_q;
    en_n      = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (|rows_s) begin
            key_n   = {lowest_set(rows_s), ~col_strobe(col_idx)};
            btn_n   = 1'b1;
            en_n    = 1'b1;
            state_n = HELD;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HELD: begin
        if (held_bit) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          btn_n     = 1'b0;
          state_n   = SCAN;
          col_idx_n = col_idx + 2'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = SCAN;
    endcase
    cols_n = col_strobe(col_idx_n);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized self-checking bench for keypad_scanner with a physical keypad
// model driving the rows and rule-based expectations for each key event.
module tb_keypad_scanner;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] pressed [4];

  int check_count = 0;
  int pass_count  = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .rows  (rows),
    .cols  (cols),
    .kp    (kif.master)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low whenever its column is strobed.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      rows[r] = ~(|(pressed[r] & ~cols));
  end

  function automatic logic [7:0] key_code(input int r, input int c);
    logic [3:0] one;
    one = 4'b0001;
    return {one << r, one << c};
  endfunction

  function automatic logic [3:0] col_pattern(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (c % 4));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int r, input int c, input logic v);
    pressed[r][c] = v;
  endtask

  task automatic clearKeys();
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
  endtask

  task automatic waitLatch(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 4 * SD + 10) begin
      tick();
      lat++;
      if (kif.en_ks) ok = 1'b1;
    end
  endtask

  task automatic pressCheck(input int er, input int c, input string tag);
    int   lat;
    logic ok;
    waitLatch(lat, ok);
    checkOutput({tag, "_latched"}, 32'(ok), 32'd1);
    checkOutput({tag, "_latency_in_bounds"}, 32'(lat >= 2 && lat <= 4 * SD + 2), 32'd1);
    checkOutput({tag, "_keypad_val"}, 32'(kif.keypad_val), 32'(key_code(er, c)));
    checkOutput({tag, "_button_on"}, 32'(kif.button_on), 32'd1);
    checkOutput({tag, "_cols_frozen"}, 32'(cols), 32'(col_pattern(c)));
    tick();
    checkOutput({tag, "_en_ks_single"}, 32'(kif.en_ks), 32'd0);
  endtask

  task automatic lockoutCheck(input int r2, input int c2, input logic [7:0] code, input string tag);
    logic seen;
    seen = 1'b0;
    applyStimulus(r2, c2, 1'b1);
    repeat (3 * SD) begin
      tick();
      if (kif.en_ks) seen = 1'b1;
    end
    checkOutput({tag, "_no_en_ks"}, 32'(seen), 32'd0);
    checkOutput({tag, "_val_held"}, 32'(kif.keypad_val), 32'(code));
    checkOutput({tag, "_still_on"}, 32'(kif.button_on), 32'd1);
  endtask

  task automatic releaseCheck(input int r, input int c, input logic bounce,
                              input logic [7:0] code, input string tag);
    int n;
    clearKeys();
    if (bounce) begin
      repeat (2) tick();
      applyStimulus(r, c, 1'b1);
      repeat (2) tick();
      checkOutput({tag, "_bounce_held"}, 32'(kif.button_on), 32'd1);
      clearKeys();
    end
    n = 0;
    while (kif.button_on && n < 4 * SD) begin
      tick();
      n++;
    end
    checkOutput({tag, "_release_delay"}, 32'(n), 32'(SD + 2));
    checkOutput({tag, "_scan_resumes"}, 32'(cols), 32'(col_pattern(c + 1)));
    checkOutput({tag, "_val_kept"}, 32'(kif.keypad_val), 32'(code));
  endtask

  initial begin
    int   r, c, r2, c2, ra, rb, lat;
    logic ok;
    clearKeys();
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("reset_cols", 32'(cols), 32'h0000000e);
    checkOutput("reset_val", 32'(kif.keypad_val), 32'd0);
    checkOutput("reset_button_on", 32'(kif.button_on), 32'd0);
    checkOutput("reset_en_ks", 32'(kif.en_ks), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 5 * SD; k++) begin
      checkOutput($sformatf("rotate_%0d", k), 32'(cols), 32'(col_pattern(k / SD)));
      tick();
    end

    applyStimulus(2, 1, 1'b1);
    pressCheck(2, 1, "press_r2c1");
    lockoutCheck(0, 3, key_code(2, 1), "lockout_r0c3");
    lockoutCheck(3, 1, key_code(2, 1), "lockout_same_col");
    releaseCheck(2, 1, 1'b1, key_code(2, 1), "bounce_r2c1");

    applyStimulus(1, 0, 1'b1);
    applyStimulus(3, 0, 1'b1);
    pressCheck(1, 0, "multirow_c0");
    releaseCheck(1, 0, 1'b0, key_code(1, 0), "multirow_release");

    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(3);
      c = $urandom_range(3);
      repeat ($urandom_range(3 * SD)) tick();
      applyStimulus(r, c, 1'b1);
      pressCheck(r, c, $sformatf("rnd%0d_press", it));
      do begin
        r2 = $urandom_range(3);
        c2 = $urandom_range(3);
      end while (r2 == r && c2 == c);
      lockoutCheck(r2, c2, key_code(r, c), $sformatf("rnd%0d_lock", it));
      releaseCheck(r, c, 1'($urandom_range(1)), key_code(r, c), $sformatf("rnd%0d_rel", it));
    end

    c  = $urandom_range(3);
    ra = $urandom_range(2);
    rb = $urandom_range(3, ra + 1);
    applyStimulus(ra, c, 1'b1);
    applyStimulus(rb, c, 1'b1);
    pressCheck(ra, c, "rnd_multirow");
    releaseCheck(ra, c, 1'b0, key_code(ra, c), "rnd_multirow_rel");

    r = $urandom_range(3);
    c = $urandom_range(3);
    applyStimulus(r, c, 1'b1);
    pressCheck(r, c, "midheld_press");
    reset = 1'b1;
    tick();
    checkOutput("midheld_reset_cols", 32'(cols), 32'h0000000e);
    checkOutput("midheld_reset_val", 32'(kif.keypad_val), 32'd0);
    checkOutput("midheld_reset_button_on", 32'(kif.button_on), 32'd0);
    checkOutput("midheld_reset_en_ks", 32'(kif.en_ks), 32'd0);
    reset = 1'b0;
    ok = 1'b0;
    repeat (2) begin
      tick();
      if (kif.en_ks) ok = 1'b1;
    end
    checkOutput("midheld_no_early_en_ks", 32'(ok), 32'd0);
    waitLatch(lat, ok);
    checkOutput("midheld_relatch", 32'(ok), 32'd1);
    checkOutput("midheld_relatch_val", 32'(kif.keypad_val), 32'(key_code(r, c)));
    clearKeys();
    repeat (SD + 4) tick();

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
